// File: rtl/router_pkt_gen_if.sv
// Router input-port bus: the packet byte stream from the generator plus the
// router's back-pressure and parity-error flags travelling the other way.
interface router_pkt_gen_if;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       busy;
  logic       error;

  // Packet source side (the generator).
  modport master (
    output pkt_valid,
    output data_out,
    input  busy,
    input  error
  );

  // Router side.
  modport slave (
    input  pkt_valid,
    input  data_out,
    output busy,
    output error
  );
endinterface

// File: rtl/router_pkt_gen.sv
// Router packet generator: stages 1..63 payload bytes in a 64x8 RAM, then
// sends header, payload and parity to the router, honouring busy and
// watching the router error flag for ERR_WIN cycles after the parity byte.
module router_pkt_gen #(
  parameter int ERR_WIN = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             pl_wr,
  input  logic [7:0]       pl_data,
  input  logic [1:0]       dest_addr,
  input  logic             start,
  output logic             tx_busy,
  output logic             done,
  output logic             pkt_err,
  output logic             cmd_err,
  output logic [5:0]       pl_count,
  router_pkt_gen_if.master rtr
);

  localparam int DATA_W = 8;
  localparam int CW     = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    PARITY,
    CHECK
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [0:63];
  logic [DATA_W-1:0] rd_p0;      // prefetched next payload byte
  logic [DATA_W-1:0] data_p1;    // byte currently presented to the router
  logic              vld_p1;
  logic [DATA_W-1:0] par_q;
  logic [5:0]        len_q;
  logic [5:0]        idx_q;
  logic [5:0]        fetch_q;
  logic [5:0]        fetch_nxt;
  logic [CW-1:0]     chk_cnt;
  logic              xfer;
  logic              wr_ok;
  logic              start_ok;

  assign xfer     = ~rtr.busy;
  assign wr_ok    = pl_wr && (state == IDLE) && (pl_count != 6'd63);
  assign start_ok = (pl_count != 6'd0) && (dest_addr != 2'd3);

  assign rtr.pkt_valid = vld_p1;
  assign rtr.data_out  = data_p1;

  // Read address for the byte that will be presented after the next
  // transfer; the RAM is read with the next-state address so the byte is
  // already in rd_p0 when the current one transfers (no bubble).
  always_comb begin
    fetch_nxt = fetch_q;
    case (state)
      HEADER:  if (xfer) fetch_nxt = 6'd1;
      PAYLOAD: if (xfer) fetch_nxt = fetch_q + 6'd1;
      default: fetch_nxt = 6'd0;
    endcase
  end

  // Staging RAM: writes only while idle, synchronous prefetch read.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[pl_count] <= pl_data;
    rd_p0 <= mem[fetch_nxt];
  end

  // Transmit FSM with registered bus and status outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      pl_count <= 6'd0;
      len_q    <= 6'd0;
      idx_q    <= 6'd0;
      fetch_q  <= 6'd0;
      par_q    <= '0;
      chk_cnt  <= '0;
      data_p1  <= '0;
      vld_p1   <= 1'b0;
      tx_busy  <= 1'b0;
      done     <= 1'b0;
      pkt_err  <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      done    <= 1'b0;
      cmd_err <= 1'b0;
      fetch_q <= fetch_nxt;
      if (wr_ok) pl_count <= pl_count + 6'd1;

      case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              len_q   <= pl_count;
              data_p1 <= {pl_count, dest_addr};
              vld_p1  <= 1'b1;
              par_q   <= '0;
              pkt_err <= 1'b0;
              tx_busy <= 1'b1;
              state   <= HEADER;
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end

        HEADER: begin
          if (xfer) begin
            par_q   <= par_q ^ data_p1;
            data_p1 <= rd_p0;
            idx_q   <= 6'd0;
            state   <= PAYLOAD;
          end
        end

        PAYLOAD: begin
          if (xfer) begin
            par_q <= par_q ^ data_p1;
            if (idx_q == len_q - 6'd1) begin
              // Last byte leaves: present the final parity with valid low.
              data_p1 <= par_q ^ data_p1;
              vld_p1  <= 1'b0;
              state   <= PARITY;
            end else begin
              data_p1 <= rd_p0;
              idx_q   <= idx_q + 6'd1;
            end
          end
        end

        PARITY: begin
          if (xfer) begin
            data_p1 <= '0;
            chk_cnt <= '0;
            state   <= CHECK;
          end
        end

        CHECK: begin
          if (rtr.error) pkt_err <= 1'b1;
          if (chk_cnt == CW'(ERR_WIN - 1)) begin
            state    <= IDLE;
            done     <= 1'b1;
            tx_busy  <= 1'b0;
            pl_count <= 6'd0;
          end else begin
            chk_cnt <= chk_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_gen.sv
// Testbench for router_pkt_gen: table of packet commands, scoreboard of
// expected router transfers, plus a reset-during-stall sequence.
module tb_router_pkt_gen;
  localparam int ERR_WIN = 3;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pl_wr;
  logic [7:0] pl_data;
  logic [1:0] dest_addr;
  logic       start;
  logic       tx_busy;
  logic       done;
  logic       pkt_err;
  logic       cmd_err;
  logic [5:0] pl_count;

  router_pkt_gen_if rif ();

  router_pkt_gen #(.ERR_WIN(ERR_WIN)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .pl_wr     (pl_wr),
    .pl_data   (pl_data),
    .dest_addr (dest_addr),
    .start     (start),
    .tx_busy   (tx_busy),
    .done      (done),
    .pkt_err   (pkt_err),
    .cmd_err   (cmd_err),
    .pl_count  (pl_count),
    .rtr       (rif)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    bit         par;
  } sb_t;

  typedef struct {
    int         n;       // bytes written before start
    logic [7:0] base;    // byte i = base + stp*i
    logic [7:0] stp;
    logic [1:0] dest;
    int         st_hdr;  // busy cycles on the header
    int         st_idx;  // payload index to stall
    int         st_len;  // busy cycles on that byte
    bit         err;     // pulse error 2 cycles after parity transfer
    bit         rej;     // start must be rejected
    logic [7:0] hdr;
    logic [7:0] par;
  } vec_t;

  int         checks   = 0;
  int         failures = 0;
  sb_t        sb[$];
  vec_t       vt[8];
  logic [7:0] mbuf[64];
  int         mcnt;
  bit         exp_perr;
  bit         mon_en;
  bit         in_pkt;
  bit         held;
  logic       hv;
  logic [7:0] hd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Observes the bus just before each rising edge; a presented byte with
  // busy low transfers at that edge and is matched against the scoreboard.
  task automatic monitor();
    sb_t e;
    bit  present;
    if (!resetn || !mon_en) begin
      in_pkt = 1'b0;
      held   = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", 32'(rif.pkt_valid), 32'(hv));
        chk("hold_data", 32'(rif.data_out), 32'(hd));
      end
      present = rif.pkt_valid || in_pkt;
      held    = present && rif.busy;
      hv      = rif.pkt_valid;
      hd      = rif.data_out;
      if (present && !rif.busy) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_xfer: got 0x%0h expected none", rif.data_out);
        end else begin
          e = sb.pop_front();
          chk("xfer_data", 32'(rif.data_out), 32'(e.data));
          chk("xfer_valid", 32'(rif.pkt_valid), 32'(!e.par));
        end
        in_pkt = rif.pkt_valid;
      end
    end
  endtask

  task automatic step();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
  endtask

  task automatic stage(input int n, input logic [7:0] base, input logic [7:0] stp);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = base + 8'(stp * i);
      pl_wr   = 1'b1;
      pl_data = d;
      if (mcnt < 63) begin
        mbuf[mcnt] = d;
        mcnt++;
      end
      step();
    end
    pl_wr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int  len, p, lat, lat_exp;
    bit  got;
    stage(v.n, v.base, v.stp);
    chk("pl_count_staged", 32'(pl_count), 32'(mcnt));
    chk("pkt_err_sticky", 32'(pkt_err), 32'(exp_perr));
    dest_addr = v.dest;
    start     = 1'b1;
    len       = mcnt;
    if (!v.rej) begin
      sb.push_back('{v.hdr, 1'b0});
      for (int i = 0; i < len; i++) sb.push_back('{mbuf[i], 1'b0});
      sb.push_back('{v.par, 1'b1});
    end
    step();
    start = 1'b0;
    if (v.rej) begin
      chk("cmd_err_pulse", 32'(cmd_err), 1);
      chk("rej_tx_busy", 32'(tx_busy), 0);
      chk("rej_pkt_valid", 32'(rif.pkt_valid), 0);
      step();
      chk("cmd_err_end", 32'(cmd_err), 0);
      chk("rej_pl_count", 32'(pl_count), 32'(mcnt));
      return;
    end
    chk("acc_cmd_err", 32'(cmd_err), 0);
    chk("acc_tx_busy", 32'(tx_busy), 1);
    chk("acc_pkt_err_clr", 32'(pkt_err), 0);
    exp_perr = v.err;
    p        = 2 + len + v.st_hdr + v.st_len;
    lat_exp  = p + ERR_WIN;
    got      = 1'b0;
    lat      = 0;
    for (int e = 1; e <= lat_exp + 20 && !got; e++) begin
      rif.busy  = (e <= v.st_hdr) ||
                  (v.st_len > 0 && e >= v.st_hdr + 2 + v.st_idx &&
                   e < v.st_hdr + 2 + v.st_idx + v.st_len);
      rif.error = v.err && (e == p + 2);
      step();
      if (done) begin
        got = 1'b1;
        lat = e;
      end
    end
    rif.busy  = 1'b0;
    rif.error = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done expected done after %0d cycles", lat_exp);
    end else begin
      chk("done_latency", 32'(lat), 32'(lat_exp));
    end
    chk("done_tx_busy", 32'(tx_busy), 0);
    chk("done_pkt_err", 32'(pkt_err), 32'(exp_perr));
    chk("done_pl_count", 32'(pl_count), 0);
    chk("sb_empty", 32'(sb.size()), 0);
    mcnt = 0;
    sb.delete();
    step();
    chk("done_pulse_end", 32'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected TB_RESULT");
    $fatal(1, "watchdog");
  end

  initial begin
    // n, base, stp, dest, st_hdr, st_idx, st_len, err, rej, hdr, par
    // 0x11^0x22^0x33 is zero, so the parity equals the header there.
    vt[0] = '{3,  8'h11, 8'h11, 2'd1, 0, 0, 0, 1'b0, 1'b0, 8'h0D, 8'h0D};
    vt[1] = '{3,  8'h11, 8'h11, 2'd1, 2, 1, 1, 1'b0, 1'b0, 8'h0D, 8'h0D};
    vt[2] = '{0,  8'h00, 8'h00, 2'd1, 0, 0, 0, 1'b0, 1'b1, 8'h00, 8'h00};
    vt[3] = '{5,  8'h01, 8'h01, 2'd3, 0, 0, 0, 1'b0, 1'b1, 8'h00, 8'h00};
    vt[4] = '{0,  8'h00, 8'h00, 2'd0, 0, 0, 0, 1'b0, 1'b0, 8'h14, 8'h15};
    vt[5] = '{2,  8'h80, 8'h01, 2'd2, 0, 0, 0, 1'b1, 1'b0, 8'h0A, 8'h0B};
    vt[6] = '{1,  8'hA5, 8'h00, 2'd0, 0, 0, 0, 1'b0, 1'b0, 8'h04, 8'hA1};
    vt[7] = '{65, 8'h00, 8'h01, 2'd2, 0, 0, 0, 1'b0, 1'b0, 8'hFE, 8'hC1};

    resetn    = 1'b0;
    pl_wr     = 1'b0;
    pl_data   = 8'h00;
    dest_addr = 2'd0;
    start     = 1'b0;
    rif.busy  = 1'b0;
    rif.error = 1'b0;
    mcnt      = 0;
    exp_perr  = 1'b0;
    mon_en    = 1'b1;
    in_pkt    = 1'b0;
    held      = 1'b0;
    hv        = 1'b0;
    hd        = 8'h00;
    #12;
    chk("rst_pkt_valid", 32'(rif.pkt_valid), 0);
    chk("rst_data_out", 32'(rif.data_out), 0);
    chk("rst_tx_busy", 32'(tx_busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pkt_err", 32'(pkt_err), 0);
    chk("rst_cmd_err", 32'(cmd_err), 0);
    chk("rst_pl_count", 32'(pl_count), 0);
    @(posedge clock);
    #1 resetn = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // Reset asserted while a payload byte is stalled.
    mon_en = 1'b0;
    stage(4, 8'h40, 8'h01);
    dest_addr = 2'd1;
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    rif.busy = 1'b1;
    step();
    step();
    chk("stall_pkt_valid", 32'(rif.pkt_valid), 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_pkt_valid", 32'(rif.pkt_valid), 0);
    chk("arst_data_out", 32'(rif.data_out), 0);
    chk("arst_tx_busy", 32'(tx_busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_pkt_err", 32'(pkt_err), 0);
    chk("arst_cmd_err", 32'(cmd_err), 0);
    chk("arst_pl_count", 32'(pl_count), 0);
    rif.busy = 1'b0;
    @(posedge clock);
    #1 resetn = 1'b1;
    mcnt     = 0;
    exp_perr = 1'b0;
    sb.delete();
    mon_en   = 1'b1;
    step();
    chk("post_rst_tx_busy", 32'(tx_busy), 0);
    chk("post_rst_pl_count", 32'(pl_count), 0);
    run_vec(vt[2]);
    run_vec(vt[6]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
